// File: rtl/mux_stim_pkg.sv
// mux_stim_pkg: shared sizes and types for the mux stimulus scheduler
package mux_stim_pkg;
  localparam int STIM_DEPTH = 20;
  localparam int DLY_W = 8;
  typedef enum logic [1:0] {CH_IN0, CH_IN1, CH_SEL, CH_BAD} chan_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef struct packed {
    logic value;
    logic [DLY_W-1:0] delay;
  } stim_entry_t;
endpackage

// File: rtl/mux_stim_scheduler_if.sv
// mux_stim_scheduler_if: load port, playback control and mux drive signals
interface mux_stim_scheduler_if;
  import mux_stim_pkg::*;
  logic load_valid, load_ready, load_value, start, abort;
  logic in0, in1, sel, busy, done, load_err;
  chan_e load_chan;
  logic [DLY_W-1:0] load_delay;
  modport master (
    output load_valid, load_chan, load_value, load_delay, start, abort,
    input load_ready, in0, in1, sel, busy, done, load_err
  );
  modport slave (
    input load_valid, load_chan, load_value, load_delay, start, abort,
    output load_ready, in0, in1, sel, busy, done, load_err
  );
endinterface

// File: rtl/mux_stim_channel.sv
// mux_stim_channel: entry FIFO plus hold counter driving one mux input
module mux_stim_channel
  import mux_stim_pkg::*;
#(
  parameter int DEPTH = STIM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  stim_entry_t push_entry,
  input  logic        flush,
  input  logic        run,
  output logic        full,
  output logic        finished,
  output logic        out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  stim_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DLY_W-1:0] cnt;
  logic pop, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign finished = count == '0 && cnt == '0;
  assign wr = push && !full;
  // a flush on the same edge wins over a pending pop, freezing the output
  assign pop = run && !flush && cnt == '0 && count != '0;
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= push_entry;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cnt <= '0;
    end else begin
      if (wr) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(wr) - CW'(pop);
      cnt <= pop ? mem[rd_ptr].delay : cnt != '0 ? cnt - DLY_W'(1) : cnt;
    end
  end
  // output keeps its last value across done/abort; only reset clears it
  always_ff @(posedge clk) out <= !rst_n ? 1'b0 : pop ? mem[rd_ptr].value : out;
endmodule

// File: rtl/mux_stim_scheduler.sv
// mux_stim_scheduler: buffers per-channel (value, delay) stimulus and plays in0/in1/sel out concurrently
module mux_stim_scheduler
  import mux_stim_pkg::*;
#(
  parameter int DEPTH = STIM_DEPTH
) (
  input logic clk,
  input logic rst_n,
  mux_stim_scheduler_if.slave bus
);
  state_e state, state_n;
  logic armed, run, flush, err_q, accept;
  logic [2:0] push, full_ch, fin, outs;
  logic [3:0] full;
  stim_entry_t entry;
  assign entry = '{value: bus.load_value, delay: bus.load_delay};
  assign run = state == RUN;
  assign flush = run && bus.abort;
  assign full = {1'b0, full_ch};
  assign accept = bus.load_valid && bus.load_ready;
  assign bus.load_ready = state == IDLE && !full[bus.load_chan];
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign push[c] = accept && bus.load_chan == chan_e'(c);
    mux_stim_channel #(.DEPTH(DEPTH)) u_ch (
      .clk(clk), .rst_n(rst_n), .push(push[c]), .push_entry(entry), .flush(flush),
      .run(run), .full(full_ch[c]), .finished(fin[c]), .out(outs[c])
    );
  end
  // finish is only judged once the first playback edge has passed, so an empty start still spends a RUN cycle
  always_comb
    state_n = state == IDLE ? (bus.start ? RUN : IDLE)
            : state == RUN  ? (bus.abort ? IDLE : armed && &fin ? DONE : RUN)
            : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      armed <= run;
      err_q <= accept && bus.load_chan == CH_BAD;
    end
  end
  assign bus.busy = run;
  assign bus.done = state == DONE;
  assign bus.load_err = err_q;
  assign bus.in0 = outs[0];
  assign bus.in1 = outs[1];
  assign bus.sel = outs[2];
endmodule

// File: tb/tb_mux_stim_scheduler.sv
// tb_mux_stim_scheduler: directed and random stimulus checked against a schedule-based model
module tb_mux_stim_scheduler;
  import mux_stim_pkg::*;
  localparam int DEPTH = STIM_DEPTH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  mux_stim_scheduler_if bus();
  mux_stim_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int cyc = 0, t0 = 0, t_end = 0;
  bit playing = 0, m_done = 0, m_err = 0, chk_on = 0;
  bit m_out [3];
  int qv [3][DEPTH];
  int qd [3][DEPTH];
  int qn [3];

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    if (playing || m_done) return 0;
    if (bus.load_chan == CH_BAD) return 1;
    return qn[int'(bus.load_chan)] < DEPTH;
  endfunction

  // model: on start, each entry k of a channel is applied at t0+1+sum of earlier (delay+1);
  // done falls at the later of t0+2 and the longest channel's t0+1+total
  always @(posedge clk) begin
    bit acc;
    int t, tot, ch;
    cyc++;
    acc = exp_ready() && bus.load_valid;
    if (!rst_n) begin
      playing = 0; m_done = 0; m_err = 0; chk_on = 1;
      for (int c = 0; c < 3; c++) begin m_out[c] = 0; qn[c] = 0; end
    end else begin
      m_err = acc && bus.load_chan == CH_BAD;
      if (m_done) m_done = 0;
      else if (playing) begin
        if (bus.abort) begin
          playing = 0;
          for (int c = 0; c < 3; c++) qn[c] = 0;
        end else begin
          for (int c = 0; c < 3; c++) begin
            t = t0 + 1;
            for (int k = 0; k < qn[c]; k++) begin
              if (t <= cyc) m_out[c] = qv[c][k] != 0;
              t += qd[c][k] + 1;
            end
          end
          if (cyc == t_end) begin
            playing = 0; m_done = 1;
            for (int c = 0; c < 3; c++) qn[c] = 0;
          end
        end
      end else begin
        if (acc && bus.load_chan != CH_BAD) begin
          ch = int'(bus.load_chan);
          qv[ch][qn[ch]] = int'(bus.load_value);
          qd[ch][qn[ch]] = int'(bus.load_delay);
          qn[ch]++;
        end
        if (bus.start) begin
          playing = 1; t0 = cyc; t_end = t0 + 2;
          for (int c = 0; c < 3; c++) begin
            tot = 0;
            for (int k = 0; k < qn[c]; k++) tot += qd[c][k] + 1;
            if (t0 + 1 + tot > t_end) t_end = t0 + 1 + tot;
          end
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("in0", bus.in0, m_out[0]);
    chk("in1", bus.in1, m_out[1]);
    chk("sel", bus.sel, m_out[2]);
    chk("busy", bus.busy, playing);
    chk("done", bus.done, m_done);
    chk("load_err", bus.load_err, m_err);
    chk("load_ready", bus.load_ready, exp_ready());
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int ch, input bit v, input int d);
    bus.load_valid = 1'b1;
    bus.load_chan = chan_e'(ch);
    bus.load_value = v;
    bus.load_delay = DLY_W'(d);
    step();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    int ndone, dk;
    bus.load_valid = 1'b0; bus.load_chan = CH_IN0; bus.load_value = 1'b0;
    bus.load_delay = '0; bus.start = 1'b0; bus.abort = 1'b0;
    rst_n = 1'b0;
    step(); step();
    chk("rst_in0", bus.in0, 0); chk("rst_in1", bus.in1, 0); chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0); chk("rst_ready", bus.load_ready, 1);
    rst_n = 1'b1;

    load(0, 1, 2); load(0, 0, 0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); chk("t1_in0_n1", bus.in0, 1); chk("t1_busy_n1", bus.busy, 1);
    step(); chk("t1_in0_n2", bus.in0, 1);
    step(); chk("t1_in0_n3", bus.in0, 1);
    step(); chk("t1_in0_n4", bus.in0, 0); chk("t1_done_n4", bus.done, 0);
    step(); chk("t1_done_n5", bus.done, 1); chk("t1_busy_n5", bus.busy, 0);
    step(); chk("t1_done_n6", bus.done, 0);

    load(0, 1, 3); load(1, 1, 2); load(1, 0, 3); load(2, 1, 0); load(2, 0, 0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    ndone = 0; dk = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.start = k == 2;
      step();
      if (bus.done) begin ndone++; dk = k; end
      if (k == 8) chk("t2_busy_at_done", bus.busy, 0);
    end
    bus.start = 1'b0;
    chk("t2_done_count", ndone, 1); chk("t2_done_edge", dk, 8);
    chk("t2_in0", bus.in0, 1); chk("t2_in1", bus.in1, 0); chk("t2_sel", bus.sel, 0);

    for (int i = 0; i < DEPTH; i++) load(1, 1'(i % 2), 0);
    bus.load_chan = CH_IN1; #1 chk("t3_ready_full", bus.load_ready, 0);
    bus.load_chan = CH_IN0; #1 chk("t3_ready_other", bus.load_ready, 1);
    load(3, 1, 5); chk("t3_load_err", bus.load_err, 1);
    step(); chk("t3_load_err_clr", bus.load_err, 0);

    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); chk("t4_in1_n1", bus.in1, 0);
    step(); chk("t4_in1_n2", bus.in1, 1);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk("t4_busy", bus.busy, 0); chk("t4_in1_frozen", bus.in1, 1);
    chk("t4_in0", bus.in0, 1); chk("t4_sel", bus.sel, 0); chk("t4_done", bus.done, 0);
    ndone = 0;
    repeat (6) begin step(); if (bus.done) ndone++; end
    chk("t4_no_done", ndone, 0);
    bus.load_chan = CH_IN1; #1 chk("t4_ready_flushed", bus.load_ready, 1);

    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); chk("t5_done_n1", bus.done, 0); chk("t5_busy_n1", bus.busy, 1);
    step(); chk("t5_done_n2", bus.done, 1); chk("t5_busy_n2", bus.busy, 0);
    chk("t5_in0", bus.in0, 1); chk("t5_in1", bus.in1, 1); chk("t5_sel", bus.sel, 0);

    repeat (4000) begin
      rst_n = $urandom_range(0, 199) != 0;
      bus.load_valid = $urandom_range(0, 1) != 0;
      bus.load_chan = chan_e'($urandom_range(0, 3));
      bus.load_value = $urandom_range(0, 1) != 0;
      bus.load_delay = $urandom_range(0, 15) == 0 ? DLY_W'($urandom_range(0, 255)) : DLY_W'($urandom_range(0, 3));
      bus.start = $urandom_range(0, 9) == 0;
      bus.abort = $urandom_range(0, 59) == 0;
      step();
    end
    rst_n = 1'b1;
    bus.load_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
